// File: rtl/flood_sequencer_if.sv
// Bundle between the flood sequencer, the selector that drives it and the board RAM.
// The slave modport is the sequencer; the master side is selector plus RAM.
interface flood_sequencer_if;
   logic       INIT_INIT;
   logic [4:0] SIZE;
   logic [3:0] COLOR_NUM;
   logic       COLOR_SEL_SIG;
   logic [2:0] COLOR_SELECTED;
   logic [9:0] MEM_ADDR;
   logic [2:0] MEM_RD_DATA;
   logic       MEM_WE;
   logic [2:0] MEM_WR_DATA;
   logic       CHANGING_COLOR;
   logic       UPDATE_DONE;
   logic       READY;
   logic       WON;
   logic [2:0] FLOOD_COLOR;
   logic [9:0] REGION_SIZE;
   logic [7:0] TRIES;

   modport slave (
      input  INIT_INIT, SIZE, COLOR_NUM, COLOR_SEL_SIG, COLOR_SELECTED, MEM_RD_DATA,
      output MEM_ADDR, MEM_WE, MEM_WR_DATA, CHANGING_COLOR, UPDATE_DONE, READY, WON,
             FLOOD_COLOR, REGION_SIZE, TRIES
   );

   modport master (
      output INIT_INIT, SIZE, COLOR_NUM, COLOR_SEL_SIG, COLOR_SELECTED, MEM_RD_DATA,
      input  MEM_ADDR, MEM_WE, MEM_WR_DATA, CHANGING_COLOR, UPDATE_DONE, READY, WON,
             FLOOD_COLOR, REGION_SIZE, TRIES
   );
endinterface

// File: rtl/flood_sequencer.sv
// Flood-It flood-fill controller: owns the flooded-region mask and repeats
// read-modify-write raster sweeps of the board RAM until the region stops growing.
module flood_sequencer (
   input  logic             CLOCK,
   input  logic             RESET,
   flood_sequencer_if.slave io_bus
);
   localparam logic [9:0] ROW_PITCH = 10'd26;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INIT_RD   = 3'd1,
      INIT_WAIT = 3'd2,
      SC_ADDR   = 3'd3,
      SC_EVAL   = 3'd4,
      PASS_END  = 3'd5,
      FINISH    = 3'd6
   } state_t;

   state_t       r_state, w_state_nxt;
   logic [675:0] r_mask, w_mask_nxt;
   logic [4:0]   r_sz, w_sz_nxt;
   logic [3:0]   r_ncol, w_ncol_nxt;
   logic [2:0]   r_newc, w_newc_nxt;
   logic         r_changed, w_changed_nxt;
   logic [4:0]   r_row, w_row_nxt;
   logic [4:0]   r_col, w_col_nxt;
   logic [9:0]   r_addr, w_addr_nxt;
   logic         r_busy, w_busy_nxt;
   logic         r_done, w_done_nxt;
   logic         r_ready, w_ready_nxt;
   logic         r_won, w_won_nxt;
   logic [2:0]   r_flood, w_flood_nxt;
   logic [9:0]   r_region, w_region_nxt;
   logic [7:0]   r_tries, w_tries_nxt;
   logic         w_we;

   logic [9:0]   w_idx, w_up_idx, w_dn_idx, w_lf_idx, w_rt_idx;
   logic [9:0]   w_area;
   logic [4:0]   w_size_in;
   logic         w_last_row, w_last_col, w_in_mask, w_nbr, w_sel_ok;
   logic [2:0]   w_rd;

   assign w_rd       = io_bus.MEM_RD_DATA;
   assign w_idx      = ({5'd0, r_row} * ROW_PITCH) + {5'd0, r_col};
   assign w_last_row = (r_row == (r_sz - 5'd1));
   assign w_last_col = (r_col == (r_sz - 5'd1));
   // Neighbour indices fall back to the cell itself at the edges so they stay in range.
   assign w_up_idx   = (r_row != 5'd0) ? (w_idx - ROW_PITCH) : w_idx;
   assign w_dn_idx   = w_last_row ? w_idx : (w_idx + ROW_PITCH);
   assign w_lf_idx   = (r_col != 5'd0) ? (w_idx - 10'd1) : w_idx;
   assign w_rt_idx   = w_last_col ? w_idx : (w_idx + 10'd1);
   assign w_in_mask  = r_mask[w_idx];
   assign w_nbr      = ((r_row != 5'd0) && r_mask[w_up_idx]) ||
                       (!w_last_row     && r_mask[w_dn_idx]) ||
                       ((r_col != 5'd0) && r_mask[w_lf_idx]) ||
                       (!w_last_col     && r_mask[w_rt_idx]);
   assign w_area     = {5'd0, r_sz} * {5'd0, r_sz};
   assign w_size_in  = (io_bus.SIZE < 5'd2)  ? 5'd2  :
                       (io_bus.SIZE > 5'd26) ? 5'd26 : io_bus.SIZE;
   assign w_sel_ok   = r_ready && !r_won &&
                       ({1'b0, io_bus.COLOR_SELECTED} < r_ncol) &&
                       (io_bus.COLOR_SELECTED != r_flood);

   // Next-state and datapath decode; INIT_INIT overrides everything, including a pending write.
   always_comb begin
      w_state_nxt   = r_state;
      w_mask_nxt    = r_mask;
      w_sz_nxt      = r_sz;
      w_ncol_nxt    = r_ncol;
      w_newc_nxt    = r_newc;
      w_changed_nxt = r_changed;
      w_row_nxt     = r_row;
      w_col_nxt     = r_col;
      w_addr_nxt    = r_addr;
      w_done_nxt    = 1'b0;
      w_ready_nxt   = r_ready;
      w_won_nxt     = r_won;
      w_flood_nxt   = r_flood;
      w_region_nxt  = r_region;
      w_tries_nxt   = r_tries;
      w_we          = 1'b0;

      if (io_bus.INIT_INIT) begin
         w_sz_nxt      = w_size_in;
         w_ncol_nxt    = io_bus.COLOR_NUM;
         w_mask_nxt    = {675'd0, 1'b1};
         w_tries_nxt   = 8'd0;
         w_won_nxt     = 1'b0;
         w_region_nxt  = 10'd1;
         w_changed_nxt = 1'b0;
         w_row_nxt     = 5'd0;
         w_col_nxt     = 5'd0;
         w_addr_nxt    = 10'd0;
         w_state_nxt   = INIT_RD;
      end else begin
         case (r_state)
            IDLE: begin
               if (io_bus.COLOR_SEL_SIG && w_sel_ok) begin
                  w_newc_nxt    = io_bus.COLOR_SELECTED;
                  w_tries_nxt   = (r_tries == 8'd255) ? r_tries : (r_tries + 8'd1);
                  w_row_nxt     = 5'd0;
                  w_col_nxt     = 5'd0;
                  w_addr_nxt    = 10'd0;
                  w_changed_nxt = 1'b0;
                  w_state_nxt   = SC_ADDR;
               end else begin
                  w_state_nxt   = IDLE;
               end
            end
            INIT_RD: w_state_nxt = INIT_WAIT;
            INIT_WAIT: begin
               w_flood_nxt   = w_rd;
               w_newc_nxt    = w_rd;
               w_row_nxt     = 5'd0;
               w_col_nxt     = 5'd0;
               w_addr_nxt    = 10'd0;
               w_changed_nxt = 1'b0;
               w_state_nxt   = SC_ADDR;
            end
            SC_ADDR: w_state_nxt = SC_EVAL;
            SC_EVAL: begin
               if (w_in_mask && (w_rd != r_newc)) begin
                  w_we = 1'b1;
               end else if (!w_in_mask && (w_rd == r_newc) && w_nbr) begin
                  w_mask_nxt[w_idx] = 1'b1;
                  w_region_nxt      = r_region + 10'd1;
                  w_changed_nxt     = 1'b1;
               end else begin
                  w_changed_nxt     = r_changed;
               end
               if (w_last_col && w_last_row) begin
                  w_state_nxt = PASS_END;
               end else if (w_last_col) begin
                  w_row_nxt   = r_row + 5'd1;
                  w_col_nxt   = 5'd0;
                  w_addr_nxt  = w_idx + ROW_PITCH - {5'd0, r_col};
                  w_state_nxt = SC_ADDR;
               end else begin
                  w_col_nxt   = r_col + 5'd1;
                  w_addr_nxt  = w_idx + 10'd1;
                  w_state_nxt = SC_ADDR;
               end
            end
            PASS_END: begin
               if (r_changed) begin
                  w_changed_nxt = 1'b0;
                  w_row_nxt     = 5'd0;
                  w_col_nxt     = 5'd0;
                  w_addr_nxt    = 10'd0;
                  w_state_nxt   = SC_ADDR;
               end else begin
                  w_state_nxt   = FINISH;
               end
            end
            FINISH: begin
               w_flood_nxt = r_newc;
               w_won_nxt   = (r_region == w_area);
               w_ready_nxt = 1'b1;
               w_done_nxt  = 1'b1;
               w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
      w_busy_nxt = (w_state_nxt != IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_state   <= IDLE;
         r_mask    <= 676'd0;
         r_sz      <= 5'd0;
         r_ncol    <= 4'd0;
         r_newc    <= 3'd0;
         r_changed <= 1'b0;
         r_row     <= 5'd0;
         r_col     <= 5'd0;
         r_addr    <= 10'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_ready   <= 1'b0;
         r_won     <= 1'b0;
         r_flood   <= 3'd0;
         r_region  <= 10'd0;
         r_tries   <= 8'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_mask    <= w_mask_nxt;
         r_sz      <= w_sz_nxt;
         r_ncol    <= w_ncol_nxt;
         r_newc    <= w_newc_nxt;
         r_changed <= w_changed_nxt;
         r_row     <= w_row_nxt;
         r_col     <= w_col_nxt;
         r_addr    <= w_addr_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_ready   <= w_ready_nxt;
         r_won     <= w_won_nxt;
         r_flood   <= w_flood_nxt;
         r_region  <= w_region_nxt;
         r_tries   <= w_tries_nxt;
      end
   end

   // The write strobe depends on the data read this cycle, so it cannot be registered.
   assign io_bus.MEM_WE         = w_we & ~RESET;
   assign io_bus.MEM_ADDR       = r_addr;
   assign io_bus.MEM_WR_DATA    = r_newc;
   assign io_bus.CHANGING_COLOR = r_busy;
   assign io_bus.UPDATE_DONE    = r_done;
   assign io_bus.READY          = r_ready;
   assign io_bus.WON            = r_won;
   assign io_bus.FLOOD_COLOR    = r_flood;
   assign io_bus.REGION_SIZE    = r_region;
   assign io_bus.TRIES          = r_tries;
endmodule

// File: tb/tb_flood_sequencer.sv
// Directed self-checking bench for flood_sequencer with a synchronous-read board RAM model.
module tb_flood_sequencer;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   flood_sequencer_if bus ();
   flood_sequencer dut (.CLOCK(clk), .RESET(rst), .io_bus(bus));

   logic [2:0] mem   [0:1023];
   logic [2:0] board [0:1023];
   logic       load_req = 1'b0;
   int         wr_cnt = 0;
   logic [9:0] last_wr_addr = 10'd0;
   logic [2:0] last_wr_data = 3'd0;
   int         n_checks = 0;
   int         n_fail = 0;

   // Board RAM: one-cycle read latency, write at MEM_ADDR, bulk preload from board[].
   always @(posedge clk) begin
      if (load_req) begin
         for (int i = 0; i < 1024; i++) mem[i] <= board[i];
      end else if (bus.MEM_WE === 1'b1) begin
         mem[bus.MEM_ADDR] <= bus.MEM_WR_DATA;
         wr_cnt            <= wr_cnt + 1;
         last_wr_addr      <= bus.MEM_ADDR;
         last_wr_data      <= bus.MEM_WR_DATA;
      end
      bus.MEM_RD_DATA <= mem[bus.MEM_ADDR];
   end

   task automatic fill_board(input logic [2:0] v);
      for (int i = 0; i < 1024; i++) board[i] = v;
   endtask

   task automatic commit_board();
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic pulse_init(input logic [4:0] sz, input logic [3:0] nc);
      bus.INIT_INIT = 1'b1; bus.SIZE = sz; bus.COLOR_NUM = nc;
      @(negedge clk);
      bus.INIT_INIT = 1'b0;
   endtask

   task automatic pulse_sel(input logic [2:0] c);
      bus.COLOR_SEL_SIG = 1'b1; bus.COLOR_SELECTED = c;
      @(negedge clk);
      bus.COLOR_SEL_SIG = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int cycles);
      cycles = 0;
      while (bus.UPDATE_DONE !== 1'b1 && cycles < limit) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic watch(input int n, output bit act);
      act = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus.CHANGING_COLOR !== 1'b0 || bus.UPDATE_DONE !== 1'b0 || bus.MEM_WE !== 1'b0) act = 1'b1;
      end
   endtask

   task automatic test_reset();
      bit we_seen = 1'b0;
      bit act;
      int w0;
      rst = 1'b1;
      bus.INIT_INIT = 1'b1; bus.COLOR_SEL_SIG = 1'b1; bus.SIZE = 5'd2;
      bus.COLOR_NUM = 4'd4; bus.COLOR_SELECTED = 3'd1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.MEM_WE !== 1'b0) we_seen = 1'b1;
      end
      n_checks++; if (we_seen !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0d expected 0", we_seen); end
      n_checks++; if ({bus.CHANGING_COLOR, bus.UPDATE_DONE, bus.READY, bus.WON} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 0000", {bus.CHANGING_COLOR, bus.UPDATE_DONE, bus.READY, bus.WON}); end
      n_checks++; if ({bus.FLOOD_COLOR, bus.REGION_SIZE, bus.TRIES} !== 21'd0) begin
         n_fail++; $display("FAIL reset_counts: got %0d/%0d/%0d expected 0/0/0", bus.FLOOD_COLOR, bus.REGION_SIZE, bus.TRIES); end
      n_checks++; if ({bus.MEM_ADDR, bus.MEM_WR_DATA} !== 13'd0) begin
         n_fail++; $display("FAIL reset_mem_if: got addr %0d data %0d expected 0", bus.MEM_ADDR, bus.MEM_WR_DATA); end
      rst = 1'b0; bus.INIT_INIT = 1'b0; bus.COLOR_SEL_SIG = 1'b0;
      @(negedge clk);
      w0 = wr_cnt;
      pulse_sel(3'd1);
      watch(6, act);
      n_checks++; if (act !== 1'b0) begin n_fail++; $display("FAIL sel_before_init_activity: got %0d expected 0", act); end
      n_checks++; if (bus.TRIES !== 8'd0 || wr_cnt != w0) begin
         n_fail++; $display("FAIL sel_before_init_tries: got tries %0d writes %0d expected 0", bus.TRIES, wr_cnt - w0); end
   endtask

   task automatic test_init_2x2();
      int cyc;
      int w0 = wr_cnt;
      fill_board(3'd1); board[0] = 3'd0;
      commit_board();
      pulse_init(5'd2, 4'd4);
      n_checks++; if (bus.CHANGING_COLOR !== 1'b1) begin n_fail++; $display("FAIL init_busy_rise: got %0d expected 1", bus.CHANGING_COLOR); end
      wait_done(40, cyc);
      n_checks++; if (cyc != 12) begin n_fail++; $display("FAIL init2_latency: got %0d expected 12", cyc); end
      n_checks++; if (bus.FLOOD_COLOR !== 3'd0 || bus.REGION_SIZE !== 10'd1) begin
         n_fail++; $display("FAIL init2_region: got color %0d size %0d expected 0/1", bus.FLOOD_COLOR, bus.REGION_SIZE); end
      n_checks++; if ({bus.READY, bus.WON, bus.CHANGING_COLOR} !== 3'b100) begin
         n_fail++; $display("FAIL init2_flags: got %b expected 100", {bus.READY, bus.WON, bus.CHANGING_COLOR}); end
      n_checks++; if (wr_cnt != w0) begin n_fail++; $display("FAIL init2_writes: got %0d expected 0", wr_cnt - w0); end
      @(negedge clk);
      n_checks++; if (bus.UPDATE_DONE !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %0d expected 0", bus.UPDATE_DONE); end
   endtask

   task automatic test_flood_2x2();
      int cyc;
      int w0 = wr_cnt;
      pulse_sel(3'd1);
      wait_done(60, cyc);
      n_checks++; if (cyc != 19) begin n_fail++; $display("FAIL flood2_latency: got %0d expected 19", cyc); end
      n_checks++; if (wr_cnt - w0 != 1 || last_wr_addr !== 10'd0 || last_wr_data !== 3'd1) begin
         n_fail++; $display("FAIL flood2_write: got n=%0d addr %0d data %0d expected 1/0/1", wr_cnt - w0, last_wr_addr, last_wr_data); end
      n_checks++; if (bus.REGION_SIZE !== 10'd4 || bus.WON !== 1'b1) begin
         n_fail++; $display("FAIL flood2_win: got size %0d won %0d expected 4/1", bus.REGION_SIZE, bus.WON); end
      n_checks++; if (bus.TRIES !== 8'd1 || bus.FLOOD_COLOR !== 3'd1) begin
         n_fail++; $display("FAIL flood2_tries: got tries %0d color %0d expected 1/1", bus.TRIES, bus.FLOOD_COLOR); end
   endtask

   task automatic test_reject();
      int cyc;
      int w0;
      bit act;
      fill_board(3'd1); board[0] = 3'd0;
      commit_board();
      pulse_init(5'd2, 4'd4);
      wait_done(40, cyc);
      @(negedge clk);
      w0 = wr_cnt;
      pulse_sel(3'd0);
      watch(6, act);
      n_checks++; if (act !== 1'b0) begin n_fail++; $display("FAIL reject_same_color: got activity %0d expected 0", act); end
      pulse_sel(3'd5);
      watch(6, act);
      n_checks++; if (act !== 1'b0 || bus.TRIES !== 8'd0) begin
         n_fail++; $display("FAIL reject_out_of_range: got activity %0d tries %0d expected 0/0", act, bus.TRIES); end
      pulse_sel(3'd1);
      pulse_sel(3'd2);
      wait_done(60, cyc);
      n_checks++; if (cyc + 1 != 19) begin n_fail++; $display("FAIL reject_busy_latency: got %0d expected 19", cyc + 1); end
      n_checks++; if (bus.TRIES !== 8'd1 || wr_cnt - w0 != 1 || last_wr_data !== 3'd1) begin
         n_fail++; $display("FAIL reject_busy_sel: got tries %0d writes %0d data %0d expected 1/1/1", bus.TRIES, wr_cnt - w0, last_wr_data); end
      watch(25, act);
      n_checks++; if (act !== 1'b0) begin n_fail++; $display("FAIL reject_not_queued: got activity %0d expected 0", act); end
      pulse_sel(3'd2);
      watch(6, act);
      n_checks++; if (act !== 1'b0 || bus.TRIES !== 8'd1) begin
         n_fail++; $display("FAIL reject_after_win: got activity %0d tries %0d expected 0/1", act, bus.TRIES); end
   endtask

   task automatic load_3x3();
      fill_board(3'd1); board[0] = 3'd0; board[26] = 3'd2; board[27] = 3'd2;
      commit_board();
   endtask

   task automatic test_3x3();
      int cyc;
      int w0;
      int done_at = -1;
      logic [9:0] rs19 = 10'd0, rs38 = 10'd0, rs57 = 10'd0;
      load_3x3();
      pulse_init(5'd3, 4'd4);
      wait_done(60, cyc);
      n_checks++; if (cyc != 22 || bus.REGION_SIZE !== 10'd1) begin
         n_fail++; $display("FAIL init3_latency: got %0d size %0d expected 22/1", cyc, bus.REGION_SIZE); end
      w0 = wr_cnt;
      pulse_sel(3'd1);
      for (int c = 1; c <= 120 && done_at < 0; c++) begin
         @(negedge clk);
         if (c == 19) rs19 = bus.REGION_SIZE;
         if (c == 38) rs38 = bus.REGION_SIZE;
         if (c == 57) rs57 = bus.REGION_SIZE;
         if (bus.UPDATE_DONE === 1'b1) done_at = c;
      end
      n_checks++; if (rs19 !== 10'd5 || rs38 !== 10'd6 || rs57 !== 10'd7) begin
         n_fail++; $display("FAIL flood3_pass_growth: got %0d/%0d/%0d expected 5/6/7", rs19, rs38, rs57); end
      n_checks++; if (done_at != 77) begin n_fail++; $display("FAIL flood3_latency: got %0d expected 77", done_at); end
      n_checks++; if (bus.REGION_SIZE !== 10'd7 || bus.WON !== 1'b0 || bus.FLOOD_COLOR !== 3'd1) begin
         n_fail++; $display("FAIL flood3_result: got size %0d won %0d color %0d expected 7/0/1", bus.REGION_SIZE, bus.WON, bus.FLOOD_COLOR); end
      n_checks++; if (wr_cnt - w0 != 1) begin n_fail++; $display("FAIL flood3_writes: got %0d expected 1", wr_cnt - w0); end
   endtask

   task automatic test_abort();
      int cyc;
      int w0;
      load_3x3();
      pulse_init(5'd3, 4'd4);
      wait_done(60, cyc);
      w0 = wr_cnt;
      pulse_sel(3'd1);
      @(negedge clk);
      n_checks++; if (bus.MEM_WE !== 1'b1) begin n_fail++; $display("FAIL abort_setup_we: got %0d expected 1", bus.MEM_WE); end
      bus.INIT_INIT = 1'b1; bus.SIZE = 5'd3; bus.COLOR_NUM = 4'd4;
      #1;
      n_checks++; if (bus.MEM_WE !== 1'b0) begin n_fail++; $display("FAIL abort_cycle_we: got %0d expected 0", bus.MEM_WE); end
      @(negedge clk);
      bus.INIT_INIT = 1'b0;
      n_checks++; if (bus.CHANGING_COLOR !== 1'b1 || bus.TRIES !== 8'd0 || bus.REGION_SIZE !== 10'd1 || bus.MEM_ADDR !== 10'd0) begin
         n_fail++; $display("FAIL abort_reinit: got busy %0d tries %0d size %0d addr %0d expected 1/0/1/0",
                            bus.CHANGING_COLOR, bus.TRIES, bus.REGION_SIZE, bus.MEM_ADDR); end
      wait_done(60, cyc);
      n_checks++; if (cyc != 22 || bus.FLOOD_COLOR !== 3'd0) begin
         n_fail++; $display("FAIL abort_init_done: got latency %0d color %0d expected 22/0", cyc, bus.FLOOD_COLOR); end
      n_checks++; if (wr_cnt != w0) begin n_fail++; $display("FAIL abort_stale_write: got %0d expected 0", wr_cnt - w0); end
   endtask

   task automatic test_saturation();
      int cyc;
      int bad = 0;
      logic [7:0] t255 = 8'd0;
      fill_board(3'd1); board[0] = 3'd0;
      commit_board();
      pulse_init(5'd2, 4'd8);
      wait_done(40, cyc);
      for (int i = 0; i < 260; i++) begin
         pulse_sel((i % 2 == 0) ? 3'd2 : 3'd3);
         wait_done(30, cyc);
         if (cyc != 10) bad++;
         if (i == 254) t255 = bus.TRIES;
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL sat_floods: got %0d bad floods expected 0", bad); end
      n_checks++; if (t255 !== 8'd255) begin n_fail++; $display("FAIL sat_at_255: got %0d expected 255", t255); end
      n_checks++; if (bus.TRIES !== 8'd255 || bus.WON !== 1'b0 || bus.REGION_SIZE !== 10'd1) begin
         n_fail++; $display("FAIL sat_hold: got tries %0d won %0d size %0d expected 255/0/1", bus.TRIES, bus.WON, bus.REGION_SIZE); end
   endtask

   task automatic test_init_wins();
      int cyc;
      int w0 = wr_cnt;
      bus.INIT_INIT = 1'b1; bus.COLOR_SEL_SIG = 1'b1; bus.COLOR_SELECTED = 3'd2;
      bus.SIZE = 5'd2; bus.COLOR_NUM = 4'd8;
      @(negedge clk);
      bus.INIT_INIT = 1'b0; bus.COLOR_SEL_SIG = 1'b0;
      wait_done(40, cyc);
      n_checks++; if (cyc != 12) begin n_fail++; $display("FAIL simul_latency: got %0d expected 12", cyc); end
      n_checks++; if (bus.TRIES !== 8'd0 || bus.FLOOD_COLOR !== 3'd3 || wr_cnt != w0) begin
         n_fail++; $display("FAIL simul_init_only: got tries %0d color %0d writes %0d expected 0/3/0", bus.TRIES, bus.FLOOD_COLOR, wr_cnt - w0); end
   endtask

   task automatic test_size26();
      int cyc;
      int w0;
      fill_board(3'd7); board[0] = 3'd0;
      commit_board();
      pulse_init(5'd26, 4'd8);
      wait_done(1500, cyc);
      n_checks++; if (cyc != 1356 || bus.REGION_SIZE !== 10'd1) begin
         n_fail++; $display("FAIL init26: got latency %0d size %0d expected 1356/1", cyc, bus.REGION_SIZE); end
      w0 = wr_cnt;
      pulse_sel(3'd7);
      wait_done(3000, cyc);
      n_checks++; if (cyc != 2707) begin n_fail++; $display("FAIL flood26_latency: got %0d expected 2707", cyc); end
      n_checks++; if (bus.REGION_SIZE !== 10'd676 || bus.WON !== 1'b1 || wr_cnt - w0 != 1) begin
         n_fail++; $display("FAIL flood26_win: got size %0d won %0d writes %0d expected 676/1/1", bus.REGION_SIZE, bus.WON, wr_cnt - w0); end
   endtask

   initial begin
      bus.INIT_INIT = 1'b0; bus.COLOR_SEL_SIG = 1'b0; bus.SIZE = 5'd2;
      bus.COLOR_NUM = 4'd4; bus.COLOR_SELECTED = 3'd0;
      rst = 1'b1;
      test_reset();
      test_init_2x2();
      test_flood_2x2();
      test_reject();
      test_3x3();
      test_abort();
      test_saturation();
      test_init_wins();
      test_size26();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
